// File: rtl/qeciphy_clk_en_div_pkg.sv
// Shared types and helpers for the clock-enable divider.
// Each channel walks CLEARED -> RUN <-> PAUSED and derives its strobe and phase from one counter.
package qeciphy_clk_en_div_pkg;

  localparam int DEFAULT_DIV_W = 3;

  typedef enum logic [1:0] {
    CH_CLEARED = 2'd0,
    CH_RUN     = 2'd1,
    CH_PAUSED  = 2'd2
  } ch_state_e;

  // Phase stays high while the count is at or below this value.
  function automatic int unsigned phaseThreshold(input int unsigned div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/qeciphy_clk_en_div_ch.sv
// One divider channel: state machine, period counter, applied ratio and registered outputs.
// A new ratio is only taken on a wrap, so a period is never cut short or stretched.
module qeciphy_clk_en_div_ch
  import qeciphy_clk_en_div_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             ce_mask_i,
  input  logic             clr_i,
  input  logic             clr_mask_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             en_o,
  output logic             phase_o,
  output logic [DIV_W-1:0] div_act_o,
  output logic             running_o
);

  ch_state_e        r_state, w_stateNext;
  logic [DIV_W-1:0] r_cnt, w_cntNext;
  logic [DIV_W-1:0] r_divAct, w_divActNext;
  logic             r_en, w_enNext;
  logic             r_phase, w_phaseNext;
  logic             r_running;

  logic             w_effCe, w_effClr, w_wrap, w_phaseStep;
  logic [DIV_W-1:0] w_cntStep, w_divStep;

  assign w_effCe     = ce_i | ce_mask_i;
  assign w_effClr    = clr_i & ~clr_mask_i;
  assign w_wrap      = (r_cnt == r_divAct);
  assign w_cntStep   = w_wrap ? '0 : r_cnt + DIV_W'(1);
  assign w_divStep   = w_wrap ? div_i : r_divAct;
  assign w_phaseStep = (32'(w_cntStep) <= phaseThreshold(32'(w_divStep)));

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_divActNext = r_divAct;
    w_enNext     = 1'b0;
    w_phaseNext  = r_phase;
    if (w_effClr) begin
      w_stateNext = CH_CLEARED;
      w_cntNext   = '0;
      w_phaseNext = 1'b0;
    end else begin
      case (r_state)
        CH_CLEARED: begin
          if (w_effCe) begin
            w_stateNext  = CH_RUN;
            w_divActNext = div_i;
            w_cntNext    = '0;
            w_enNext     = 1'b1;
            w_phaseNext  = 1'b1;
          end
        end
        CH_RUN, CH_PAUSED: begin
          if (w_effCe) begin
            w_stateNext  = CH_RUN;
            w_cntNext    = w_cntStep;
            w_divActNext = w_divStep;
            w_enNext     = w_wrap;
            w_phaseNext  = w_phaseStep;
          end else begin
            w_stateNext = CH_PAUSED;
          end
        end
        default: begin
          w_stateNext = CH_CLEARED;
          w_cntNext   = '0;
          w_phaseNext = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CH_CLEARED;
      r_cnt     <= '0;
      r_divAct  <= '0;
      r_en      <= 1'b0;
      r_phase   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_divAct  <= w_divActNext;
      r_en      <= w_enNext;
      r_phase   <= w_phaseNext;
      r_running <= (w_stateNext == CH_RUN);
    end
  end

  assign en_o      = r_en;
  assign phase_o   = r_phase;
  assign div_act_o = r_divAct;
  assign running_o = r_running;

endmodule

// File: rtl/qeciphy_clk_en_div.sv
// Multi-channel clock-enable divider: independent channels sharing one clock and reset.
module qeciphy_clk_en_div
  import qeciphy_clk_en_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DEFAULT_DIV_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ce_i,
  input  logic [NUM_CH-1:0]       ce_mask_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [NUM_CH-1:0]       clr_mask_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       en_o,
  output logic [NUM_CH-1:0]       phase_o,
  output logic [NUM_CH*DIV_W-1:0] div_act_o,
  output logic [NUM_CH-1:0]       running_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    qeciphy_clk_en_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ce_i      (ce_i[g]),
      .ce_mask_i (ce_mask_i[g]),
      .clr_i     (clr_i[g]),
      .clr_mask_i(clr_mask_i[g]),
      .div_i     (div_i[g*DIV_W +: DIV_W]),
      .en_o      (en_o[g]),
      .phase_o   (phase_o[g]),
      .div_act_o (div_act_o[g*DIV_W +: DIV_W]),
      .running_o (running_o[g])
    );
  end

endmodule

// File: tb/tb_qeciphy_clk_en_div.sv
// Self-checking bench for qeciphy_clk_en_div: directed scenarios then random traffic,
// every cycle compared against a period-position model of each channel.
module tb_qeciphy_clk_en_div;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 3;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       ce, ceMask, clr, clrMask;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       en, phase, running;
  logic [NUM_CH*DIV_W-1:0] divAct;

  int nChecks = 0;
  int nBad    = 0;
  int cycle   = 0;

  // Model: mode 0 = idle (cleared), 1 = counting, 2 = held.
  int mMode[NUM_CH];
  int mPos[NUM_CH];
  int mDiv[NUM_CH];
  int mEn[NUM_CH];
  int mPh[NUM_CH];

  qeciphy_clk_en_div #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce),
    .ce_mask_i (ceMask),
    .clr_i     (clr),
    .clr_mask_i(clrMask),
    .div_i     (div),
    .en_o      (en),
    .phase_o   (phase),
    .div_act_o (divAct),
    .running_o (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nBad++;
      $display("[TB] FAIL %s cyc%0d: got %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs the DUT samples on that edge.
  task automatic modelStep();
    for (int c = 0; c < NUM_CH; c++) begin
      int req;
      bit effCe, effClr;
      req    = int'(div[c*DIV_W +: DIV_W]);
      effCe  = ce[c] | ceMask[c];
      effClr = clr[c] & ~clrMask[c];
      if (rst) begin
        mMode[c] = 0; mPos[c] = 0; mDiv[c] = 0; mEn[c] = 0; mPh[c] = 0;
      end else if (effClr) begin
        mMode[c] = 0; mPos[c] = 0; mEn[c] = 0; mPh[c] = 0;
      end else if (mMode[c] == 0) begin
        mEn[c] = 0;
        if (effCe) begin
          mMode[c] = 1; mDiv[c] = req; mPos[c] = 0; mEn[c] = 1; mPh[c] = 1;
        end
      end else if (effCe) begin
        mMode[c] = 1;
        mPos[c]  = (mPos[c] + 1) % (mDiv[c] + 1);
        mEn[c]   = (mPos[c] == 0) ? 1 : 0;
        if (mPos[c] == 0) mDiv[c] = req;
        mPh[c]   = (2 * mPos[c] <= mDiv[c]) ? 1 : 0;
      end else begin
        mMode[c] = 2; mEn[c] = 0;
      end
    end
  endtask

  // Hold the current inputs for n cycles, checking every output after each edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      cycle++;
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        checkOutput($sformatf("en ch%0d", c), int'(en[c]), mEn[c]);
        checkOutput($sformatf("phase ch%0d", c), int'(phase[c]), mPh[c]);
        checkOutput($sformatf("running ch%0d", c), int'(running[c]), (mMode[c] == 1) ? 1 : 0);
        checkOutput($sformatf("div_act ch%0d", c), int'(divAct[c*DIV_W +: DIV_W]), mDiv[c]);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      mMode[c] = 0; mPos[c] = 0; mDiv[c] = 0; mEn[c] = 0; mPh[c] = 0;
    end
    rst = 1'b1; ce = '0; ceMask = '0; clr = '0; clrMask = '0; div = '0;
    applyStimulus(3);

    // Basic divide-by-4 on ch0.
    rst = 1'b0; div = {3'd0, 3'd3}; ce = 2'b01;
    applyStimulus(12);

    // Ratio change requested mid-period only lands on the wrap.
    clr = 2'b01; applyStimulus(1);
    clr = 2'b00; applyStimulus(2);
    div = {3'd0, 3'd1}; applyStimulus(10);

    // Pause at cnt=2, then the same with the enable masked.
    div = {3'd0, 3'd3};
    clr = 2'b01; applyStimulus(1);
    clr = 2'b00; applyStimulus(3);
    ce = 2'b00; applyStimulus(3);
    ce = 2'b01; applyStimulus(8);
    ceMask = 2'b01; ce = 2'b00; applyStimulus(8);
    ceMask = 2'b00; ce = 2'b01;

    // Clear together with enable, then the same with the clear masked.
    clr = 2'b01; applyStimulus(2);
    clr = 2'b00; applyStimulus(6);
    clrMask = 2'b01; clr = 2'b01; applyStimulus(6);
    clrMask = 2'b00; clr = 2'b00;

    // Extremes of the ratio range.
    div = {3'd0, 3'd0};
    clr = 2'b01; applyStimulus(1);
    clr = 2'b00; applyStimulus(6);
    div = {3'd0, 3'd7};
    clr = 2'b01; applyStimulus(1);
    clr = 2'b00; applyStimulus(18);

    // Two channels with different ratios, reset mid-period.
    div = {3'd5, 3'd2}; ce = 2'b11;
    clr = 2'b11; applyStimulus(1);
    clr = 2'b00; applyStimulus(7);
    rst = 1'b1; applyStimulus(1);
    rst = 1'b0; applyStimulus(14);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        ce[c]      = ($urandom_range(0, 3) != 0);
        ceMask[c]  = ($urandom_range(0, 7) == 0);
        clr[c]     = ($urandom_range(0, 15) == 0);
        clrMask[c] = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 7) == 0) div = NUM_CH*DIV_W'($urandom);
      applyStimulus(1);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/qeciphy_clk_en_div.md
Name: qeciphy_clk_en_div

Overview:
Parametrised, synthesisable clock-enable divider with BUFG_GT-style CE/CEMASK/CLR/CLRMASK semantics.
- Generates per-channel divided enable strobes and divided-phase levels inside a single clock domain, so no extra global clock buffers are needed.
- Generalises the 3-bit fixed-primitive divider to NUM_CH independent channels of DIV_W-bit ratio.
- Ratio changes are glitch-free and take effect only at a period boundary.
- Feeds low-rate datapath and housekeeping logic in the PHY.

Parameters:
- NUM_CH, 2, number of independent divider channels (≥1).
- DIV_W, 3, width of each divide field; ratio = div+1, range 1..2^DIV_W.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- ce_i  input  NUM_CH  per-channel count enable.
- ce_mask_i  input  NUM_CH  1 = ignore ce_i (treated as enabled).
- clr_i  input  NUM_CH  per-channel synchronous clear.
- clr_mask_i  input  NUM_CH  1 = ignore clr_i.
- div_i  input  NUM_CH*DIV_W  requested divide field per channel; channel n at bits [n*DIV_W +: DIV_W].
- en_o  output  NUM_CH  one-cycle enable strobe, once per divided period.
- phase_o  output  NUM_CH  divided-clock level.
- div_act_o  output  NUM_CH*DIV_W  currently applied divide field.
- running_o  output  NUM_CH  1 when channel state is RUN.

Behaviour:
- Per channel: eff_ce = ce_i | ce_mask_i; eff_clr = clr_i & ~clr_mask_i. All outputs are registered.
- Reset (rst=1 at edge): state=CLEARED, cnt=0, div_act=0, en_o=0, phase_o=0, running_o=0 on all channels.
- FSM states per channel: CLEARED, RUN, PAUSED.
- Priority: rst > eff_clr > eff_ce.
- eff_clr in any state: next state CLEARED; cnt=0, en_o=0, phase_o=0. div_act holds.
- eff_clr and eff_ce both high on the same edge: clear wins; start occurs on the first edge with eff_clr=0 and eff_ce=1.
- CLEARED, eff_ce=1: transition to RUN; div_act<=div_i, cnt<=0, en_o<=1, phase_o<=1. The first strobe is immediate, on the edge that samples eff_ce=1.
- RUN, eff_ce=1 (counting step):
  - wrap = (cnt==div_act).
  - cnt <= wrap ? 0 : cnt+1.
  - en_o <= wrap.
  - On wrap, div_act <= div_i.
  - phase_o <= (cnt_next <= div_act_next>>1). phase_o is high for the first floor(ratio/2)+... cycles, i.e. for counts 0..div_act>>1.
- RUN, eff_ce=0: transition to PAUSED; cnt, phase_o and div_act hold; en_o<=0.
- PAUSED, eff_ce=0: everything holds; en_o=0.
- PAUSED, eff_ce=1: perform the counting step, then go to RUN. Resume continues from the held cnt; there is no restart strobe.
- div_i changes mid-period are ignored until wrap. div_act_o always reflects the applied value.
- div_act=0 (divide by 1): wrap every cycle, so en_o=1 continuously and phase_o=1 continuously while RUN.
- cnt width is DIV_W. It never exceeds div_act, so no overflow is possible.
- Channels are fully independent; no cross-channel alignment.

Decomposition:
- Package qeciphy_clk_en_div_pkg holds:
  - state enum (CLEARED, RUN, PAUSED) as 2-bit logic typedef;
  - default DIV_W constant;
  - helper function computing the phase-high threshold (div>>1).
- Sub-module qeciphy_clk_en_div_ch implements one channel (FSM, counter, div_act, output registers).
- The top module is a generate loop over NUM_CH with field slicing of div_i and div_act_o.

Test Plan:
- Reset, then div_i=3, ce_i=1, masks 0 on ch0 → en_o = 1,0,0,0 repeating; phase_o = 1,1,0,0 repeating; en_o=1 on the first edge sampling ce_i; running_o=1.
- Running div=3; change div_i to 1 when cnt=1 → current period completes (4 cycles total), div_act_o=1 after wrap, then en_o = 1,0 and phase_o = 1,0 repeating.
- div=3; drop ce_i for 3 cycles at cnt=2 → en_o=0 and running_o=0 during the pause, next strobe delayed exactly 3 cycles. Repeat with ce_mask_i=1 → no pause.
- Running div=3; assert clr_i together with ce_i=1 for 2 cycles → outputs 0 after the first edge. Release → en_o=1 on the next edge. Repeat with clr_mask_i=1 → no effect.
- div=0 → en_o and phase_o held high continuously. div=7 → 8-cycle period, phase_o high for 4 cycles.
- NUM_CH=2, ch0 div=2, ch1 div=5; assert rst mid-period → all outputs 0 on the next edge. After release, channels restart independently with periods 3 and 6.
